// File: rtl/btb_predictor_if.sv
// Fetch-side lookup, ID-side training and statistics bundle for btb_predictor.
// master = core (drives lookups/updates), slave = predictor.
interface btb_predictor_if #(
    parameter int XLEN = 32
);
    // No backpressure anywhere: lookup_en_i and upd_valid_i are single-cycle
    // valid strobes with no ready, sampled on every clock; predictions are
    // combinational and valid in the same cycle as lookup_pc_i.
    logic            lookup_en_i;
    logic [XLEN-1:0] lookup_pc_i;
    logic            pred_hit_o;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_next_pc_o;
    logic            upd_valid_i;
    logic [XLEN-1:0] upd_pc_i;
    logic [XLEN-1:0] upd_target_i;
    logic            upd_taken_i;
    logic            upd_jump_i;
    logic            upd_mispred_i;
    logic            flush_i;
    logic [31:0]     stat_lookups_o;
    logic [31:0]     stat_hits_o;
    logic [31:0]     stat_mispreds_o;

    modport master (
        output lookup_en_i, lookup_pc_i, upd_valid_i, upd_pc_i, upd_target_i,
               upd_taken_i, upd_jump_i, upd_mispred_i, flush_i,
        input  pred_hit_o, pred_taken_o, pred_next_pc_o,
               stat_lookups_o, stat_hits_o, stat_mispreds_o
    );

    modport slave (
        input  lookup_en_i, lookup_pc_i, upd_valid_i, upd_pc_i, upd_target_i,
               upd_taken_i, upd_jump_i, upd_mispred_i, flush_i,
        output pred_hit_o, pred_taken_o, pred_next_pc_o,
               stat_lookups_o, stat_hits_o, stat_mispreds_o
    );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; zero-cycle prediction, trained at posedge.
// Define BTB_PREDICTOR_STATS_EN to build the saturating lookup/hit/mispredict counters.
module btb_predictor #(
    parameter  int XLEN    = 32,
    parameter  int ENTRIES = 16,
    localparam int IDXW    = $clog2(ENTRIES),
    localparam int TAGW    = XLEN - 2 - IDXW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    btb_predictor_if.slave   bus
);
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] jmp_q, jmp_d;
    logic [TAGW-1:0]    tag_q    [ENTRIES];
    logic [TAGW-1:0]    tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];

    logic [IDXW-1:0] lk_idx, up_idx;
    logic [TAGW-1:0] lk_tag, up_tag;
    logic            lk_hit, lk_taken, up_hit;

    assign lk_idx = bus.lookup_pc_i[IDXW+1:2];
    assign lk_tag = bus.lookup_pc_i[XLEN-1:IDXW+2];
    assign up_idx = bus.upd_pc_i[IDXW+1:2];
    assign up_tag = bus.upd_pc_i[XLEN-1:IDXW+2];

    // Reads the registered table only, so a same-cycle update is not bypassed.
    always_comb begin
        lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken = lk_hit && (jmp_q[lk_idx] || ctr_q[lk_idx][1]);
        up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    end

    assign bus.pred_hit_o     = lk_hit;
    assign bus.pred_taken_o   = lk_taken;
    assign bus.pred_next_pc_o = lk_taken ? target_q[lk_idx] : bus.lookup_pc_i + XLEN'(4);

    always_comb begin
        valid_d  = valid_q;
        jmp_d    = jmp_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (bus.flush_i) begin
            valid_d = '0;
        end else if (bus.upd_valid_i) begin
            if (up_hit) begin
                // Jump entries pin the counter high and never count down.
                if (bus.upd_jump_i)
                    ctr_d[up_idx] = 2'd3;
                else if (bus.upd_taken_i && ctr_q[up_idx] != 2'd3)
                    ctr_d[up_idx] = ctr_q[up_idx] + 2'd1;
                else if (!bus.upd_taken_i && !jmp_q[up_idx] && ctr_q[up_idx] != 2'd0)
                    ctr_d[up_idx] = ctr_q[up_idx] - 2'd1;
                if (bus.upd_taken_i)
                    target_d[up_idx] = bus.upd_target_i;
                jmp_d[up_idx] = bus.upd_jump_i;
            end else if (bus.upd_taken_i) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bus.upd_target_i;
                ctr_d[up_idx]    = 2'd2;
                jmp_d[up_idx]    = bus.upd_jump_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            jmp_q   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'd1;
            end
        end else begin
            valid_q  <= valid_d;
            jmp_q    <= jmp_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bus.lookup_pc_i[1:0], bus.upd_pc_i[1:0]};

`ifdef BTB_PREDICTOR_STATS_EN
    logic [31:0] lookups_q, lookups_d, hits_q, hits_d, mispreds_q, mispreds_d;

    // Saturating counters; flush_i deliberately leaves them alone.
    always_comb begin
        lookups_d  = lookups_q;
        hits_d     = hits_q;
        mispreds_d = mispreds_q;
        if (bus.lookup_en_i && lookups_q != 32'hFFFF_FFFF)
            lookups_d = lookups_q + 32'd1;
        if (bus.lookup_en_i && lk_hit && hits_q != 32'hFFFF_FFFF)
            hits_d = hits_q + 32'd1;
        if (bus.upd_valid_i && bus.upd_mispred_i && mispreds_q != 32'hFFFF_FFFF)
            mispreds_d = mispreds_q + 32'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lookups_q  <= '0;
            hits_q     <= '0;
            mispreds_q <= '0;
        end else begin
            lookups_q  <= lookups_d;
            hits_q     <= hits_d;
            mispreds_q <= mispreds_d;
        end
    end

    assign bus.stat_lookups_o  = lookups_q;
    assign bus.stat_hits_o     = hits_q;
    assign bus.stat_mispreds_o = mispreds_q;
`else
    logic unused_stat_inputs;
    assign unused_stat_inputs  = ^{bus.lookup_en_i, bus.upd_mispred_i};
    assign bus.stat_lookups_o  = '0;
    assign bus.stat_hits_o     = '0;
    assign bus.stat_mispreds_o = '0;
`endif
endmodule

// File: tb/tb_btb_predictor.sv
// Randomized + directed bench for btb_predictor against a table-level reference model.
module tb_btb_predictor;
    localparam int XLEN = 32;
    localparam int ENT  = 16;
    localparam int W    = XLEN + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    btb_predictor_if #(.XLEN(XLEN)) bus ();
    btb_predictor #(.XLEN(XLEN), .ENTRIES(ENT)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // Reference model: one slot per index holding the full PC it was trained on.
    bit          m_valid [ENT];
    logic [31:0] m_pc    [ENT];
    logic [31:0] m_tgt   [ENT];
    int          m_ctr   [ENT];
    bit          m_jmp   [ENT];
    int          m_lookups, m_hits, m_mispreds;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % ENT);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int s = slot(pc);
        return m_valid[s] && (m_pc[s] / 4 == pc / 4);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0; m_pc[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1; m_jmp[i] = 0;
        end
        m_lookups = 0; m_hits = 0; m_mispreds = 0;
    endtask

    task automatic model_update(input bit uv, input logic [31:0] upc, input logic [31:0] utgt,
                                input bit tk, input bit jmp, input bit fl);
        int s = slot(upc);
        if (fl) begin
            for (int i = 0; i < ENT; i++) m_valid[i] = 0;
        end else if (uv) begin
            if (model_hit(upc)) begin
                if (jmp) m_ctr[s] = 3;
                else if (tk) m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
                else if (!m_jmp[s]) m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                if (tk) m_tgt[s] = utgt;
                m_jmp[s] = jmp;
            end else if (tk) begin
                m_valid[s] = 1; m_pc[s] = upc; m_tgt[s] = utgt; m_ctr[s] = 2; m_jmp[s] = jmp;
            end
        end
    endtask

    // Called one step after a posedge; returns one step after the next posedge.
    task automatic drive(input bit en, input logic [31:0] lpc, input bit uv,
                         input logic [31:0] upc, input logic [31:0] utgt, input bit tk,
                         input bit jmp, input bit mis, input bit fl);
        bit h, t;
        logic [31:0] nxt;
        bus.lookup_en_i   = en;
        bus.lookup_pc_i   = lpc;
        bus.upd_valid_i   = uv;
        bus.upd_pc_i      = upc;
        bus.upd_target_i  = utgt;
        bus.upd_taken_i   = tk;
        bus.upd_jump_i    = jmp;
        bus.upd_mispred_i = mis;
        bus.flush_i       = fl;
        if (en) begin
            h   = model_hit(lpc);
            t   = h && (m_jmp[slot(lpc)] || m_ctr[slot(lpc)] >= 2);
            nxt = t ? m_tgt[slot(lpc)] : lpc + 32'd4;
            exp_q.push_back({h, t, nxt});
            m_lookups++;
            if (h) m_hits++;
        end
        if (uv && mis) m_mispreds++;
        @(posedge clk);
        model_update(uv, upc, utgt, tk, jmp, fl);
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        drive(1, pc, 0, '0, '0, 0, 0, 0, 0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input bit tk, input bit jmp);
        drive(0, '0, 1, pc, tgt, tk, jmp, 0, 0);
    endtask

    task automatic check_stats(input string tag);
`ifdef BTB_PREDICTOR_STATS_EN
        check({tag, "_lookups"},  bus.stat_lookups_o,  m_lookups);
        check({tag, "_hits"},     bus.stat_hits_o,     m_hits);
        check({tag, "_mispreds"}, bus.stat_mispreds_o, m_mispreds);
`else
        check({tag, "_lookups"},  bus.stat_lookups_o,  32'd0);
        check({tag, "_hits"},     bus.stat_hits_o,     32'd0);
        check({tag, "_mispreds"}, bus.stat_mispreds_o, 32'd0);
`endif
    endtask

    function automatic logic [31:0] rand_pc();
        return (32'($urandom_range(0, 3)) << 28) | (32'($urandom_range(0, 31)) << 2);
    endfunction

    // Monitor: every enabled lookup cycle is a presented prediction.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && bus.lookup_en_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pred_queue: got prediction with no expectation at pc %h", bus.lookup_pc_i);
            end else begin
                e = exp_q.pop_front();
                check("pred_hit",     {31'd0, bus.pred_hit_o},   {31'd0, e[W-1]});
                check("pred_taken",   {31'd0, bus.pred_taken_o}, {31'd0, e[W-2]});
                check("pred_next_pc", bus.pred_next_pc_o,        e[XLEN-1:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] upc, lpc;
        bit jmp, tk;
        model_reset();
        bus.lookup_en_i = 0; bus.lookup_pc_i = 32'h40;
        bus.upd_valid_i = 0; bus.upd_pc_i = '0; bus.upd_target_i = '0;
        bus.upd_taken_i = 0; bus.upd_jump_i = 0; bus.upd_mispred_i = 0; bus.flush_i = 0;
        #3;
        check("reset_hit",  {31'd0, bus.pred_hit_o},   32'd0);
        check("reset_taken", {31'd0, bus.pred_taken_o}, 32'd0);
        check("reset_next", bus.pred_next_pc_o,        32'h44);
        check_stats("reset");
        @(posedge clk); #1 rst = 0;

        // Allocation, counter decay and saturation at 0.
        upd(32'h40, 32'h80, 1, 0);
        look(32'h40);
        upd(32'h40, 32'h0, 0, 0);
        upd(32'h40, 32'h0, 0, 0);
        look(32'h40);
        upd(32'h40, 32'h0, 0, 0);
        upd(32'h40, 32'h84, 1, 0);
        look(32'h40);
        // Jump entry resists not-taken training.
        upd(32'h100, 32'h200, 1, 1);
        for (int i = 0; i < 5; i++) upd(32'h100, 32'h0, 0, 1);
        look(32'h100);
        // Aliasing at index 0, then wrap of pc+4.
        upd(32'h80, 32'h300, 1, 0);
        look(32'h40);
        look(32'h80);
        look(32'hFFFF_FFFC);
        // Flush beats a same-cycle allocation.
        drive(1, 32'h80, 1, 32'h340, 32'h400, 1, 0, 0, 1);
        look(32'h80);
        look(32'h100);
        look(32'h340);

        for (int i = 0; i < 400; i++) begin
            upc = rand_pc();
            jmp = upc[6];
            tk  = jmp ? 1'b1 : 1'($urandom_range(0, 1));
            lpc = ($urandom_range(0, 1) != 0) ? upc : rand_pc();
            drive($urandom_range(0, 3) != 0, lpc, $urandom_range(0, 2) != 0, upc,
                  $urandom & 32'hFFFF_FFFC, tk, jmp, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 39) == 0);
        end
        bus.lookup_en_i = 0;
        check_stats("random");

        // Asynchronous reset mid-cycle drops the pending allocation.
        bus.lookup_pc_i = 32'h40; bus.upd_valid_i = 1; bus.upd_pc_i = 32'h500;
        bus.upd_target_i = 32'h900; bus.upd_taken_i = 1; bus.upd_jump_i = 0; bus.flush_i = 0;
        #2 rst = 1;
        #1;
        check("async_rst_hit",  {31'd0, bus.pred_hit_o}, 32'd0);
        check("async_rst_next", bus.pred_next_pc_o,      32'h44);
        model_reset();
        check_stats("async_rst");
        @(posedge clk); #1;
        bus.upd_valid_i = 0;
        rst = 0;
        look(32'h500);
        upd(32'h500, 32'h900, 1, 0);
        look(32'h500);

        // Statistics burst: 10 lookups, 4 hits, 2 mispredict updates.
        upd(32'h40, 32'h80, 1, 0);
        for (int i = 0; i < 10; i++)
            drive(1, (i < 4) ? 32'h40 : 32'h1000 + 32'(i * 4), i >= 8, 32'h600, '0, 0, 0, 1, 0);
        bus.lookup_en_i = 0;
        check_stats("burst");
`ifdef BTB_PREDICTOR_STATS_EN
        check("burst_lookups_abs", bus.stat_lookups_o, 32'd12);
`endif
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
